cla_adder_pipe: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder with valid/ready handshake; next generation of the
//   32-bit combinational CLA. Splits operand into STAGES segments, one CLA segment per pipeline stage,

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_adder_pipe_if.sv | 30 +++
 rtl/cla_seg.sv | 70 +++++++
 rtl/cla_adder_pipe.sv | 120 ++++++++++++
 tb/tb_cla_adder_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead adder.
// The per-stage control bundle lives here; operand and sum vectors are
// width-dependent and are wrapped around it inside the top module.
package cla_pkg;

    localparam int CLA_WIDTH  = 32;
    localparam int CLA_BLK    = 4;
    localparam int CLA_STAGES = 2;

    // Bits added by each pipeline stage.
    function automatic int seg_cnt(input int width, input int stages);
        return width / stages;
    endfunction

    // Control bits that travel with every operand set through the pipe.
    // carry holds the carry out of the most recently completed segment and
    // c_msb the carry into the top bit of that segment (used for overflow).
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
        logic c_msb;
    } cla_ctrl_t;

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Valid/ready operand and result bundle of the pipelined CLA adder.
// master = operand source / result consumer, slave = the adder.
interface cla_adder_pipe_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

endinterface

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead segment built from BLK-bit groups.
// Group generate/propagate feed a flat lookahead network for the group
// carries; bit carries inside each group are then expanded from those.
module cla_seg #(
    parameter int SEG = 16,
    parameter int BLK = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);
    localparam int NG = SEG / BLK;

    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gg;
    logic [NG-1:0]  gp;
    logic [NG:0]    gc;
    logic           cj;
    logic           pr;
    logic           cr;

    // Bit P/G, group P/G, lookahead group carries, then per-bit carries and sum.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gg = '0;
        gp = '1;
        gc = '0;
        c  = '0;
        cj = 1'b0;
        pr = 1'b0;
        cr = 1'b0;

        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < BLK; i++) begin
                gg[j] = g[j*BLK+i] | (p[j*BLK+i] & gg[j]);
                gp[j] = gp[j] & p[j*BLK+i];
            end
        end

        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            cj = gg[j];
            pr = gp[j];
            for (int i = j - 1; i >= 0; i--) begin
                cj = cj | (pr & gg[i]);
                pr = pr & gp[i];
            end
            gc[j+1] = cj | (pr & ci);
        end

        for (int j = 0; j < NG; j++) begin
            cr = gc[j];
            for (int i = 0; i < BLK; i++) begin
                c[j*BLK+i] = cr;
                cr = g[j*BLK+i] | (p[j*BLK+i] & cr);
            end
        end

        s     = p ^ c;
        co    = gc[NG];
        c_msb = c[SEG-1];
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder with valid/ready handshake.
// Each of the STAGES stages adds one SEG-bit slice; the carry is registered
// between stages while untouched operand bits and finished sum bits ride
// along in the stage registers. The whole pipe advances as one unit.
// Optional feature: define CLA_SUB_EN to enable subtraction via the sub input
// (b inverted, carry-in forced to 1). Without it the block is add-only.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int BLK    = CLA_BLK,
    parameter int STAGES = CLA_STAGES
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_adder_pipe_if.slave bus
);
    localparam int SEG = seg_cnt(WIDTH, STAGES);

    typedef struct packed {
        cla_ctrl_t        ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t           stage_q  [STAGES];
    stage_t           stage_d  [STAGES];
    stage_t           stage_in [STAGES];
    logic             init_q;
    logic             init_d;
    logic             adv;
    logic             in_rdy;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] seg_s;
    logic [STAGES-1:0] seg_co;
    logic [STAGES-1:0] seg_cm;

    // A single advance enable keeps every stage in lockstep; a stalled full
    // output freezes the whole pipe. init_q keeps in_ready low until the
    // first clock after reset release.
    assign adv    = bus.out_ready | ~stage_q[STAGES-1].ctrl.valid;
    assign in_rdy = init_q & adv;

`ifdef CLA_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // Stage inputs: stage 0 takes the bus operands, later stages their predecessor.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_in[k] = '0;
        end
        stage_in[0].ctrl.valid = bus.in_valid & in_rdy;
        stage_in[0].ctrl.carry = cin_eff;
        stage_in[0].ctrl.sub   = bus.sub;
        stage_in[0].ctrl.c_msb = 1'b0;
        stage_in[0].a          = bus.a;
        stage_in[0].b          = b_eff;
        stage_in[0].s          = '0;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        cla_seg #(
            .SEG (SEG),
            .BLK (BLK)
        ) u_seg (
            .a     (stage_in[k].a[k*SEG +: SEG]),
            .b     (stage_in[k].b[k*SEG +: SEG]),
            .ci    (stage_in[k].ctrl.carry),
            .s     (seg_s[k*SEG +: SEG]),
            .co    (seg_co[k]),
            .c_msb (seg_cm[k])
        );
    end

    // Next stage contents: hold on stall, otherwise take the input with this stage's slice added.
    always_comb begin
        init_d = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (adv) begin
                stage_d[k]                = stage_in[k];
                stage_d[k].s[k*SEG +: SEG] = seg_s[k*SEG +: SEG];
                stage_d[k].ctrl.carry     = seg_co[k];
                stage_d[k].ctrl.c_msb     = seg_cm[k];
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            init_q <= init_d;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = stage_q[STAGES-1].ctrl.valid;
    assign bus.s         = stage_q[STAGES-1].s;
    assign bus.cout      = stage_q[STAGES-1].ctrl.carry;
    assign bus.ovf       = stage_q[STAGES-1].ctrl.carry ^ stage_q[STAGES-1].ctrl.c_msb;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: three instances (32/2, 64/4, 16/1) driven in turn.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(32)) if32 ();
    cla_adder_pipe_if #(.WIDTH(64)) if64 ();
    cla_adder_pipe_if #(.WIDTH(16)) if16 ();

    cla_adder_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    cla_adder_pipe #(.WIDTH(64), .BLK(4), .STAGES(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
    cla_adder_pipe #(.WIDTH(16), .BLK(4), .STAGES(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        int          sel;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t tbl[$];
    res_t sb0[$];
    res_t sb1[$];
    res_t sb2[$];
    logic [63:0] cur_a   [3];
    logic [63:0] cur_b   [3];
    logic        cur_cin [3];
    logic        cur_sub [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int w_of(input int sel);
        case (sel)
            0: return 32;
            1: return 64;
            default: return 16;
        endcase
    endfunction

    function automatic int st_of(input int sel);
        case (sel)
            0: return 2;
            1: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int sel);
        logic [63:0] one = 64'd1;
        if (sel == 1) return '1;
        return (one << w_of(sel)) - 64'd1;
    endfunction

    function automatic res_t model(input int sel, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        int          w  = w_of(sel);
        logic [63:0] m  = mask_of(sel);
        logic [63:0] bb = b & m;
        logic        c  = cin;
        logic [64:0] sum;
        res_t        r;
`ifdef CLA_SUB_EN
        if (sub) begin
            bb = ~b & m;
            c  = 1'b1;
        end
`else
        c = c | (sub & 1'b0);
`endif
        sum    = {1'b0, a & m} + {1'b0, bb} + {64'd0, c};
        r.s    = sum[63:0] & m;
        r.cout = sum[w];
        r.ovf  = (a[w-1] == bb[w-1]) && (r.s[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub);
        cur_a[sel]   = a & mask_of(sel);
        cur_b[sel]   = b & mask_of(sel);
        cur_cin[sel] = cin;
        cur_sub[sel] = sub;
        case (sel)
            0: begin if32.in_valid = v; if32.a = a[31:0]; if32.b = b[31:0]; if32.cin = cin; if32.sub = sub; end
            1: begin if64.in_valid = v; if64.a = a;       if64.b = b;       if64.cin = cin; if64.sub = sub; end
            default: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic v);
        case (sel)
            0: if32.out_ready = v;
            1: if64.out_ready = v;
            default: if16.out_ready = v;
        endcase
    endtask

    function automatic logic get_ivld(input int sel);
        case (sel) 0: return if32.in_valid; 1: return if64.in_valid; default: return if16.in_valid; endcase
    endfunction
    function automatic logic get_irdy(input int sel);
        case (sel) 0: return if32.in_ready; 1: return if64.in_ready; default: return if16.in_ready; endcase
    endfunction
    function automatic logic get_ovld(input int sel);
        case (sel) 0: return if32.out_valid; 1: return if64.out_valid; default: return if16.out_valid; endcase
    endfunction
    function automatic logic get_ordy(input int sel);
        case (sel) 0: return if32.out_ready; 1: return if64.out_ready; default: return if16.out_ready; endcase
    endfunction
    function automatic logic [63:0] get_s(input int sel);
        case (sel) 0: return {32'd0, if32.s}; 1: return if64.s; default: return {48'd0, if16.s}; endcase
    endfunction
    function automatic logic get_cout(input int sel);
        case (sel) 0: return if32.cout; 1: return if64.cout; default: return if16.cout; endcase
    endfunction
    function automatic logic get_ovf(input int sel);
        case (sel) 0: return if32.ovf; 1: return if64.ovf; default: return if16.ovf; endcase
    endfunction

    function automatic int sb_size(input int sel);
        case (sel) 0: return sb0.size(); 1: return sb1.size(); default: return sb2.size(); endcase
    endfunction
    task automatic sb_push(input int sel, input res_t r);
        case (sel) 0: sb0.push_back(r); 1: sb1.push_back(r); default: sb2.push_back(r); endcase
    endtask
    task automatic sb_pop(input int sel, output res_t r);
        case (sel) 0: r = sb0.pop_front(); 1: r = sb1.pop_front(); default: r = sb2.pop_front(); endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input int sel, input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input logic sub, input logic [63:0] s, input logic cout, input logic ovf);
        vec_t v;
        v.sel = sel; v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.s = s; v.cout = cout; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    // Scoreboard: every accepted operand set queues a model result; every delivered result is checked in order.
    always @(negedge clk) begin
        res_t e;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (get_ovld(k) && get_ordy(k)) begin
                    if (sb_size(k) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb%0d_extra: result 0x%0h delivered with no pending transfer", k, get_s(k));
                    end else begin
                        sb_pop(k, e);
                        chk($sformatf("sb%0d_s", k), get_s(k), e.s);
                        chk($sformatf("sb%0d_cout", k), {63'd0, get_cout(k)}, {63'd0, e.cout});
                        chk($sformatf("sb%0d_ovf", k), {63'd0, get_ovf(k)}, {63'd0, e.ovf});
                    end
                end
                if (get_ivld(k) && get_irdy(k))
                    sb_push(k, model(k, cur_a[k], cur_b[k], cur_cin[k], cur_sub[k]));
            end
        end
    end

    task automatic check_lat(input string tag, input vec_t v);
        int sel = v.sel;
        drive(sel, 1'b1, v.a, v.b, v.cin, v.sub);
        chk({tag, "_irdy"}, {63'd0, get_irdy(sel)}, 64'd1);
        step();
        drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < st_of(sel) - 1; i++) begin
            chk({tag, "_early"}, {63'd0, get_ovld(sel)}, 64'd0);
            step();
        end
        chk({tag, "_vld"}, {63'd0, get_ovld(sel)}, 64'd1);
        chk({tag, "_s"}, get_s(sel), v.s);
        chk({tag, "_cout"}, {63'd0, get_cout(sel)}, {63'd0, v.cout});
        chk({tag, "_ovf"}, {63'd0, get_ovf(sel)}, {63'd0, v.ovf});
        step();
    endtask

    task automatic b2b(input int sel, input int n);
        int run = 0;
        set_ordy(sel, 1'b1);
        #1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    drive(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    chk($sformatf("b2b%0d_irdy", sel), {63'd0, get_irdy(sel)}, 64'd1);
                    step();
                end
                drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            end
            begin
                int t = 0;
                while (!get_ovld(sel) && t < 20) begin
                    step();
                    t++;
                end
                for (int i = 0; i < n; i++) begin
                    if (get_ovld(sel)) run++;
                    step();
                end
            end
        join
        chk($sformatf("b2b%0d_run", sel), 64'(run), 64'(n));
        chk($sformatf("b2b%0d_drained", sel), 64'(sb_size(sel)), 64'd0);
    endtask

    task automatic bp(input int sel);
        logic        held = 1'b1;
        logic        acc;
        logic [63:0] cap = '0;
        int          frozen = 0;
        set_ordy(sel, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            chk($sformatf("bp%0d_irdy_fill", sel), {63'd0, get_irdy(sel)}, 64'd1);
            step();
        end
        drive(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            set_ordy(sel, cyc >= 5);
            #1;
            if (!get_ordy(sel) && get_ovld(sel)) begin
                if (frozen == 0) cap = get_s(sel);
                else chk($sformatf("bp%0d_s_frozen", sel), get_s(sel), cap);
                chk($sformatf("bp%0d_irdy_stall", sel), {63'd0, get_irdy(sel)}, 64'd0);
                frozen++;
            end
            acc = held && get_irdy(sel);
            if (cyc >= 5 && !held && sb_size(sel) == 0) break;
            step();
            if (acc) begin
                drive(sel, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
                held = 1'b0;
            end
        end
        chk($sformatf("bp%0d_stall_seen", sel), 64'(frozen >= 2), 64'd1);
        chk($sformatf("bp%0d_held_taken", sel), {63'd0, held}, 64'd0);
        chk($sformatf("bp%0d_drained", sel), 64'(sb_size(sel)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
            set_ordy(k, 1'b1);
        end

        add_vec(0, 64'h0000_0005, 64'h0000_0003, 1'b0, 1'b0, 64'h0000_0008, 1'b0, 1'b0);
        add_vec(0, 64'h1234_5678, 64'h8765_4321, 1'b0, 1'b0, 64'h9999_9999, 1'b0, 1'b0);
        add_vec(0, 64'hFFFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h0000_0000, 1'b1, 1'b0);
        add_vec(0, 64'h7FFF_FFFF, 64'h0000_0001, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        add_vec(0, 64'h8000_0000, 64'h8000_0000, 1'b0, 1'b0, 64'h0000_0000, 1'b1, 1'b1);
        add_vec(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF, 1'b1, 1'b0);
        add_vec(0, 64'h0000_FFFF, 64'h0000_0000, 1'b1, 1'b0, 64'h0001_0000, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
        add_vec(0, 64'h0000_0005, 64'h0000_0003, 1'b0, 1'b1, 64'h0000_0002, 1'b1, 1'b0);
        add_vec(0, 64'h0000_0003, 64'h0000_0005, 1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        add_vec(0, 64'h8000_0000, 64'h0000_0001, 1'b1, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1);
`else
        add_vec(0, 64'h0000_0005, 64'h0000_0003, 1'b0, 1'b1, 64'h0000_0008, 1'b0, 1'b0);
        add_vec(0, 64'h0000_0003, 64'h0000_0005, 1'b0, 1'b1, 64'h0000_0008, 1'b0, 1'b0);
`endif
        add_vec(1, 64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0);
        add_vec(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        add_vec(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        add_vec(1, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        add_vec(2, 64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0);
        add_vec(2, 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        add_vec(2, 64'h7FFF, 64'h1, 1'b0, 1'b0, 64'h8000, 1'b0, 1'b1);
        add_vec(2, 64'h1234, 64'h8765, 1'b1, 1'b0, 64'h999A, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_ovld", k), {63'd0, get_ovld(k)}, 64'd0);
            chk($sformatf("rst%0d_s", k), get_s(k), 64'd0);
            chk($sformatf("rst%0d_cout", k), {63'd0, get_cout(k)}, 64'd0);
            chk($sformatf("rst%0d_ovf", k), {63'd0, get_ovf(k)}, 64'd0);
            chk($sformatf("rst%0d_irdy", k), {63'd0, get_irdy(k)}, 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_irdy_low", {63'd0, get_irdy(0)}, 64'd0);
        step();
        for (int k = 0; k < 3; k++)
            chk($sformatf("rel%0d_irdy_high", k), {63'd0, get_irdy(k)}, 64'd1);

        foreach (tbl[i]) check_lat($sformatf("vec%0d", i), tbl[i]);

        for (int k = 0; k < 3; k++) begin
            b2b(k, 8);
            bp(k);
        end

        // Reset with two results in flight on the 32-bit instance.
        set_ordy(0, 1'b1);
        drive(0, 1'b1, 64'h1111_1111, 64'h2222_2222, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 64'h3333_3333, 64'h4444_4444, 1'b1, 1'b0);
        step();
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("mid_pre_vld", {63'd0, get_ovld(0)}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_ovld", {63'd0, get_ovld(0)}, 64'd0);
        chk("mid_s", get_s(0), 64'd0);
        chk("mid_cout", {63'd0, get_cout(0)}, 64'd0);
        sb0.delete();
        sb1.delete();
        sb2.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_irdy_low", {63'd0, get_irdy(0)}, 64'd0);
        step();
        chk("mid_rel_irdy_high", {63'd0, get_irdy(0)}, 64'd1);
        check_lat("post_rst", tbl[1]);

        repeat (4) step();
        for (int k = 0; k < 3; k++)
            chk($sformatf("final%0d_sb_empty", k), 64'(sb_size(k)), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
